// File: rtl/sprinkler_pkg.sv
// Shared types and sizes for the sprinkler zone scheduler.
package sprinkler_pkg;

  localparam int unsigned NUM_ZONES = 8;
  localparam int unsigned ZONE_W    = 3;

  typedef enum logic [2:0] {
    IDLE,
    SEEK,
    WATER,
    GAP,
    DONE
  } state_e;

endpackage

// File: rtl/sprinkler_zone_seek.sv
// Finds the lowest enabled zone at or above a start index; nothing is found
// once the pointer has run past the last zone.
module sprinkler_zone_seek
  import sprinkler_pkg::*;
(
  input  logic [NUM_ZONES-1:0] i_mask,
  input  logic [ZONE_W-1:0]    i_start,
  input  logic                 i_end,
  output logic                 o_found_c,
  output logic [ZONE_W-1:0]    o_index_c
);

  // Scan from the top so the lowest qualifying index is the last one written.
  always_comb begin
    o_found_c = 1'b0;
    o_index_c = '0;
    for (int i = NUM_ZONES - 1; i >= 0; i--) begin
      if (!i_end && i_mask[i] && (ZONE_W'(i) >= i_start)) begin
        o_found_c = 1'b1;
        o_index_c = ZONE_W'(i);
      end
    end
  end

endmodule

// File: rtl/sprinkler_zone_scheduler.sv
// Drives the 3-to-8 valve decoder so each enabled zone waters in turn,
// with a valve-off gap between zones, rain pause and abort.
module sprinkler_zone_scheduler
  import sprinkler_pkg::*;
#(
  parameter int unsigned TIMER_W   = 16,
  parameter int unsigned GAP_TICKS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 rain,
  input  logic [NUM_ZONES-1:0] zone_mask,
  input  logic [TIMER_W-1:0]   duration,
  output logic                 e,
  output logic                 a,
  output logic                 b,
  output logic                 c,
  output logic                 busy,
  output logic                 done
);

  state_e               r_state, w_state_nx;
  logic [ZONE_W-1:0]    r_ptr, w_ptr_nx;
  logic                 r_end, w_end_nx;
  logic [TIMER_W-1:0]   r_cnt, w_cnt_nx;
  logic [TIMER_W-1:0]   r_dur, w_dur_nx;
  logic [NUM_ZONES-1:0] r_mask, w_mask_nx;
  logic                 r_e, r_busy, r_done;
  logic                 w_found;
  logic [ZONE_W-1:0]    w_idx;
  logic [ZONE_W:0]      w_ptr_inc;

  // Carry out of the pointer increment is the end-of-list flag.
  assign w_ptr_inc = {1'b0, r_ptr} + (ZONE_W + 1)'(1);

  sprinkler_zone_seek u_seek (
    .i_mask    (r_mask),
    .i_start   (r_ptr),
    .i_end     (r_end),
    .o_found_c (w_found),
    .o_index_c (w_idx)
  );

  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_end_nx   = r_end;
    w_cnt_nx   = r_cnt;
    w_dur_nx   = r_dur;
    w_mask_nx  = r_mask;
    if (abort) begin
      w_state_nx = IDLE;
      w_ptr_nx   = '0;
      w_end_nx   = 1'b0;
      w_cnt_nx   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            w_mask_nx  = zone_mask;
            w_dur_nx   = duration;
            w_ptr_nx   = '0;
            w_end_nx   = 1'b0;
            w_state_nx = ((zone_mask == '0) || (duration == '0)) ? DONE : SEEK;
          end
        end
        SEEK: begin
          if (w_found) begin
            w_ptr_nx   = w_idx;
            w_cnt_nx   = r_dur;
            w_state_nx = WATER;
          end else begin
            w_state_nx = DONE;
          end
        end
        WATER: begin
          if (tick && !rain) begin
            if (r_cnt == TIMER_W'(1)) begin
              if (GAP_TICKS == 0) begin
                {w_end_nx, w_ptr_nx} = w_ptr_inc;
                w_state_nx           = SEEK;
              end else begin
                w_cnt_nx   = TIMER_W'(GAP_TICKS);
                w_state_nx = GAP;
              end
            end else begin
              w_cnt_nx = r_cnt - TIMER_W'(1);
            end
          end
        end
        GAP: begin
          if (tick) begin
            if (r_cnt == TIMER_W'(1)) begin
              {w_end_nx, w_ptr_nx} = w_ptr_inc;
              w_state_nx           = SEEK;
            end else begin
              w_cnt_nx = r_cnt - TIMER_W'(1);
            end
          end
        end
        DONE:    w_state_nx = IDLE;
        default: w_state_nx = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they align with r_state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_end   <= 1'b0;
      r_cnt   <= '0;
      r_dur   <= '0;
      r_mask  <= '0;
      r_e     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      r_end   <= w_end_nx;
      r_cnt   <= w_cnt_nx;
      r_dur   <= w_dur_nx;
      r_mask  <= w_mask_nx;
      r_e     <= (w_state_nx == WATER) && !rain;
      r_busy  <= (w_state_nx != IDLE);
      r_done  <= (w_state_nx == DONE);
    end
  end

  assign e    = r_e;
  assign a    = r_ptr[2];
  assign b    = r_ptr[1];
  assign c    = r_ptr[0];
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_sprinkler_zone_scheduler.sv
// Directed and randomized bench for the sprinkler zone scheduler, checked
// against per-run expectations derived from the zone mask and duration.
module tb_sprinkler_zone_scheduler;

  localparam int unsigned TW = 16;

  logic          clk = 1'b0;
  logic          rst_n, tick, start, abort, rain;
  logic [7:0]    zone_mask;
  logic [TW-1:0] duration;
  logic          e, a, b, c, busy, done;
  logic          e0, a0, b0, c0, busy0, done0;

  int checks = 0;
  int errors = 0;

  // Monitor state: watered ticks per zone, order zones were watered, pulses.
  int wat [8];
  int zq [$];
  int done_cnt, gap_cnt, phase;
  bit seen_water, last_tick, auto_tick;

  always #5 clk = ~clk;

  sprinkler_zone_scheduler #(.TIMER_W(TW), .GAP_TICKS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .abort(abort),
    .rain(rain), .zone_mask(zone_mask), .duration(duration),
    .e(e), .a(a), .b(b), .c(c), .busy(busy), .done(done)
  );

  sprinkler_zone_scheduler #(.TIMER_W(TW), .GAP_TICKS(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .abort(abort),
    .rain(rain), .zone_mask(zone_mask), .duration(duration),
    .e(e0), .a(a0), .b(b0), .c(c0), .busy(busy0), .done(done0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 8; i++) wat[i] = 0;
    zq.delete();
    done_cnt   = 0;
    gap_cnt    = 0;
    seen_water = 1'b0;
  endtask

  // One clock: account for the tick about to be consumed, then sample after the edge.
  task automatic cyc();
    logic [2:0] z;
    logic       rs;
    if (auto_tick) tick = (phase % 4 == 0);
    z = {a, b, c};
    if (e && tick && !rain) begin
      wat[z]++;
      if (zq.size() == 0 || zq[$] != int'(z)) zq.push_back(int'(z));
      seen_water = 1'b1;
    end else if (busy && !e && tick && !rain && seen_water) begin
      gap_cnt++;
    end
    last_tick = tick;
    rs        = rain;
    @(posedge clk);
    #1;
    phase++;
    if (done) done_cnt++;
    if (rs && rst_n) chk("rain_closes_valve", 32'(e), 0);
    start = 1'b0;
    abort = 1'b0;
    if (auto_tick) tick = 1'b0;
  endtask

  task automatic wait_e(input string tag);
    int n = 0;
    while (e !== 1'b1 && n < 400) begin cyc(); n++; end
    chk(tag, 32'(e), 1);
  endtask

  task automatic run_to_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin cyc(); n++; end
    chk({tag, "_done_seen"}, 32'(done), 1);
    cyc();
    chk({tag, "_idle_after_done"}, 32'(busy), 0);
  endtask

  // Expected: every enabled zone, ascending, each watered exactly dur ticks, one done.
  task automatic check_run(input string tag, input logic [7:0] m, input int dur);
    int exp_q [$];
    for (int i = 0; i < 8; i++) if (m[i]) exp_q.push_back(i);
    chk({tag, "_zone_count"}, zq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < zq.size(); i++)
      chk($sformatf("%s_order%0d", tag, i), zq[i], exp_q[i]);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_ticks_z%0d", tag, i), wat[i], m[i] ? dur : 0);
    chk({tag, "_done_pulses"}, done_cnt, 1);
  endtask

  initial begin
    logic [7:0]    m;
    logic [TW-1:0] d;
    bit            do_ab, aborted;
    int            ab_at, n, k;

    rst_n = 1'b0; start = 1'b1; abort = 1'b0; rain = 1'b0; tick = 1'b0;
    zone_mask = 8'h01; duration = 16'd1; auto_tick = 1'b0; phase = 0;
    clear_mon();

    // Reset held with start asserted.
    for (int i = 0; i < 3; i++) begin start = 1'b1; cyc(); end
    chk("rst_e", 32'(e), 0);
    chk("rst_abc", 32'({a, b, c}), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    cyc();
    chk("rst_release_busy", 32'(busy), 0);
    start = 1'b1;
    cyc();
    chk("first_start_busy", 32'(busy), 1);
    chk("first_start_seek_e", 32'(e), 0);
    cyc();
    chk("first_start_water_e", 32'(e), 1);
    abort = 1'b1;
    cyc();

    // Basic three-zone sequence.
    auto_tick = 1'b1;
    clear_mon();
    zone_mask = 8'b1000_0101; duration = 16'd3; start = 1'b1;
    run_to_done("basic");
    check_run("basic", 8'b1000_0101, 3);
    chk("basic_gap_ticks", gap_cnt, 3);

    // Rain pause after two watered ticks, lasting ten ticks.
    clear_mon();
    zone_mask = 8'b0000_0010; duration = 16'd5; start = 1'b1;
    wait_e("rain_water_start");
    n = 0;
    while (wat[1] < 2 && n < 400) begin cyc(); n++; end
    rain = 1'b1;
    k = 0; n = 0;
    while (k < 10 && n < 400) begin cyc(); n++; if (last_tick) k++; end
    rain = 1'b0;
    chk("rain_frozen_count", wat[1], 2);
    run_to_done("rain");
    check_run("rain", 8'b0000_0010, 5);

    // Abort while watering zone 2, then a fresh cycle on zone 0.
    clear_mon();
    zone_mask = 8'h04; duration = 16'd5; start = 1'b1;
    wait_e("abort_water_start");
    chk("abort_zone2_abc", 32'({a, b, c}), 3'b010);
    abort = 1'b1;
    cyc();
    chk("abort_e", 32'(e), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_abc", 32'({a, b, c}), 0);
    cyc(); cyc();
    chk("abort_no_done", done_cnt, 0);
    clear_mon();
    zone_mask = 8'h01; duration = 16'd2; start = 1'b1;
    run_to_done("after_abort");
    check_run("after_abort", 8'h01, 2);

    // Degenerate starts finish through DONE at once.
    clear_mon();
    zone_mask = 8'h00; duration = 16'd3; start = 1'b1;
    cyc();
    chk("mask0_done", 32'(done), 1);
    chk("mask0_busy", 32'(busy), 1);
    chk("mask0_e", 32'(e), 0);
    cyc();
    chk("mask0_idle", 32'(busy), 0);
    chk("mask0_pulse_once", done_cnt, 1);
    clear_mon();
    zone_mask = 8'hFF; duration = 16'd0; start = 1'b1;
    cyc();
    chk("dur0_done", 32'(done), 1);
    cyc();
    chk("dur0_idle", 32'(busy), 0);
    chk("dur0_no_water", zq.size(), 0);

    // Start while busy is ignored, including its new mask and duration.
    clear_mon();
    zone_mask = 8'h01; duration = 16'd2; start = 1'b1;
    wait_e("busy_start_water");
    zone_mask = 8'hFF; duration = 16'd1; start = 1'b1;
    cyc();
    run_to_done("busy_start");
    check_run("busy_start", 8'h01, 2);

    // Tick coinciding with rain must not decrement.
    auto_tick = 1'b0; tick = 1'b0;
    clear_mon();
    zone_mask = 8'h01; duration = 16'd2; start = 1'b1;
    cyc(); cyc();
    chk("tr_water_e", 32'(e), 1);
    tick = 1'b1; rain = 1'b1; cyc(); tick = 1'b0;
    rain = 1'b0; cyc();
    chk("tr_rain_fall_reassert", 32'(e), 1);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("tr_still_water", 32'(e), 1);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("tr_gap_e", 32'(e), 0);
    chk("tr_gap_busy", 32'(busy), 1);
    tick = 1'b1; cyc(); tick = 1'b0;
    run_to_done("tick_rain");
    check_run("tick_rain", 8'h01, 2);

    // Start together with abort from IDLE stays idle.
    zone_mask = 8'h01; duration = 16'd1; start = 1'b1; abort = 1'b1;
    cyc();
    chk("start_abort_busy", 32'(busy), 0);
    cyc();
    chk("start_abort_busy_later", 32'(busy), 0);

    // No-gap instance: one SEEK cycle between zones.
    abort = 1'b1; cyc();
    chk("gap0_idle", 32'(busy0), 0);
    zone_mask = 8'h03; duration = 16'd1; start = 1'b1;
    cyc(); cyc();
    chk("gap0_z0_e", 32'(e0), 1);
    chk("gap0_z0_abc", 32'({a0, b0, c0}), 3'b000);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("gap0_seek_e", 32'(e0), 0);
    chk("gap0_seek_busy", 32'(busy0), 1);
    cyc();
    chk("gap0_z1_e", 32'(e0), 1);
    chk("gap0_z1_abc", 32'({a0, b0, c0}), 3'b001);
    tick = 1'b1; cyc(); tick = 1'b0;
    cyc();
    chk("gap0_done", 32'(done0), 1);
    abort = 1'b1; cyc();

    // Randomized cycles with rain toggling between ticks and occasional abort.
    auto_tick = 1'b1;
    for (int r = 0; r < 25; r++) begin
      m       = 8'($urandom_range(1, 255));
      d       = TW'($urandom_range(1, 4));
      do_ab   = ($urandom_range(0, 4) == 0);
      ab_at   = $urandom_range(5, 60);
      aborted = 1'b0;
      clear_mon();
      zone_mask = m; duration = d; start = 1'b1;
      n = 0;
      while (done !== 1'b1 && n < 3000) begin
        if (do_ab && n == ab_at) begin abort = 1'b1; aborted = 1'b1; end
        cyc();
        n++;
        if (aborted) break;
        if (last_tick && $urandom_range(0, 3) == 0) rain = ~rain;
      end
      rain = 1'b0;
      if (aborted) begin
        chk("rnd_abort_busy", 32'(busy), 0);
        chk("rnd_abort_e", 32'(e), 0);
        chk("rnd_abort_no_done", done_cnt, 0);
        for (int i = 0; i < 8; i++)
          if (!m[i]) chk($sformatf("rnd_abort_unmasked_z%0d", i), wat[i], 0);
        abort = 1'b1; cyc();
      end else begin
        chk("rnd_done_seen", 32'(done), 1);
        cyc();
        chk("rnd_idle_after_done", 32'(busy), 0);
        check_run($sformatf("rnd%0d", r), m, int'(d));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
